// File: rtl/banner_pkg.sv
// banner_pkg: shared constants for the scrolling banner.
//   Glyph codes, scroll-mode encodings and the active-low seven-segment
//   patterns ({dp,g,f,e,d,c,b,a}, dp always off).
package banner_pkg;

  localparam logic [3:0] GLYPH_BLANK = 4'hA;
  localparam logic [3:0] GLYPH_DASH  = 4'hB;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam logic [7:0] SSEG_0     = 8'hC0;
  localparam logic [7:0] SSEG_1     = 8'hF9;
  localparam logic [7:0] SSEG_2     = 8'hA4;
  localparam logic [7:0] SSEG_3     = 8'hB0;
  localparam logic [7:0] SSEG_4     = 8'h99;
  localparam logic [7:0] SSEG_5     = 8'h92;
  localparam logic [7:0] SSEG_6     = 8'h82;
  localparam logic [7:0] SSEG_7     = 8'hF8;
  localparam logic [7:0] SSEG_8     = 8'h80;
  localparam logic [7:0] SSEG_9     = 8'h90;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_DASH  = 8'hBF;

endpackage

// File: rtl/banner_scroller_if.sv
// banner_scroller_if: message write port of the banner.
//   wr_en   - write strobe
//   wr_addr - message index (out-of-range indices are ignored by the slave)
//   wr_data - 4-bit glyph code
// master drives the write, slave (the banner) receives it.
interface banner_scroller_if #(
  parameter int MSG_LEN = 10
) ();
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/banner_glyph_decoder.sv
// banner_glyph_decoder: combinational glyph code -> seven-segment pattern.
//   glyph - 4-bit code (0-9 digits, B dash, A/C-F blank)
//   sseg  - active-low {dp,g..a}, dp always off
module banner_glyph_decoder
  import banner_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [7:0] sseg
);

  always_comb begin
    sseg = SSEG_BLANK;
    case (glyph)
      4'h0:       sseg = SSEG_0;
      4'h1:       sseg = SSEG_1;
      4'h2:       sseg = SSEG_2;
      4'h3:       sseg = SSEG_3;
      4'h4:       sseg = SSEG_4;
      4'h5:       sseg = SSEG_5;
      4'h6:       sseg = SSEG_6;
      4'h7:       sseg = SSEG_7;
      4'h8:       sseg = SSEG_8;
      4'h9:       sseg = SSEG_9;
      GLYPH_DASH: sseg = SSEG_DASH;
      default:    sseg = SSEG_BLANK;
    endcase
  end

endmodule

// File: rtl/banner_scroller.sv
// banner_scroller: scrolling message banner on a multiplexed 7-seg display.
//   clk, reset      - clock, synchronous active-high reset
//   enable          - 1 advances the scroll prescaler, 0 freezes the window
//   dir             - wrap mode direction (0 increment, 1 decrement)
//   mode            - MODE_WRAP / MODE_BOUNCE
//   wr              - message write port (slave modport)
//   an              - active-low one-hot anode enables (bit k = digit k)
//   sseg            - active-low segments {dp,g..a}
// Digit k shows mem[(offset+k) mod MSG_LEN]; an and sseg are registered
// together from the current digit index so they never disagree.
module banner_scroller
  import banner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 10,
  parameter int SCROLL_DIV  = 50_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  dir,
  input  logic                  mode,
  banner_scroller_if.slave      wr,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            sseg
);

  localparam int AW = (MSG_LEN > 1)     ? $clog2(MSG_LEN)     : 1;
  localparam int DW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
  localparam int SW = (SCROLL_DIV > 1)  ? $clog2(SCROLL_DIV)  : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [AW:0]   MSG_LEN_W    = (AW+1)'(MSG_LEN);
  localparam logic [AW-1:0] OFF_LAST     = AW'(MSG_LEN - 1);
  localparam logic [AW-1:0] MAXOFF       = AW'(MSG_LEN - NUM_DIGITS);
  localparam logic [DW-1:0] DIGIT_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCROLL_LAST  = SW'(SCROLL_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [3:0]            mem_q [MSG_LEN];
  logic [3:0]            mem_d [MSG_LEN];
  logic [AW-1:0]         offset_q, offset_d;
  logic                  bounce_dir_q, bounce_dir_d;
  logic [SW-1:0]         scroll_cnt_q, scroll_cnt_d;
  logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  logic                  step;
  logic                  bounce_up;
  logic [AW-1:0]         bounce_nxt;
  logic [AW:0]           win_sum;
  logic [AW-1:0]         win_idx;

  always_comb begin
    mem_d = mem_q;
    if (wr.wr_en && ({1'b0, wr.wr_addr} < MSG_LEN_W)) begin
      mem_d[wr.wr_addr] = wr.wr_data;
    end
  end

  always_comb begin
    step         = 1'b0;
    scroll_cnt_d = scroll_cnt_q;
    if (enable) begin
      step         = (scroll_cnt_q == SCROLL_LAST);
      scroll_cnt_d = step ? '0 : scroll_cnt_q + 1'b1;
    end
  end

  // Bounce direction is chosen from position first, so a window left sitting
  // on an endpoint by wrap mode still moves inward instead of overshooting.
  always_comb begin
    offset_d     = offset_q;
    bounce_dir_d = bounce_dir_q;
    bounce_up    = (offset_q == '0) ? 1'b1 :
                   (offset_q == MAXOFF) ? 1'b0 : !bounce_dir_q;
    bounce_nxt   = bounce_up ? offset_q + 1'b1 : offset_q - 1'b1;
    if (step) begin
      if (mode == MODE_WRAP) begin
        if (!dir) offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
        else      offset_d = (offset_q == '0) ? OFF_LAST : offset_q - 1'b1;
      end else if (MSG_LEN == NUM_DIGITS) begin
        offset_d = '0;
      end else if (offset_q > MAXOFF) begin
        offset_d     = MAXOFF;
        bounce_dir_d = 1'b1;
      end else begin
        offset_d     = bounce_nxt;
        bounce_dir_d = bounce_up ? (bounce_nxt == MAXOFF) : (bounce_nxt != '0);
      end
    end
  end

  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    digit_d       = digit_q;
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      digit_d       = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
    end
  end

  // offset < MSG_LEN and digit < NUM_DIGITS <= MSG_LEN, so a single
  // conditional subtraction gives the modulo.
  always_comb begin
    win_sum = {1'b0, offset_q} + (AW+1)'(digit_q);
    if (win_sum >= MSG_LEN_W) win_sum = win_sum - MSG_LEN_W;
    win_idx = win_sum[AW-1:0];
    an_d    = ~(NUM_DIGITS'(1) << digit_q);
  end

  banner_glyph_decoder u_decoder (
    .glyph (mem_q[win_idx]),
    .sseg  (sseg_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) mem_q[i] <= GLYPH_BLANK;
      offset_q      <= '0;
      bounce_dir_q  <= 1'b0;
      scroll_cnt_q  <= '0;
      refresh_cnt_q <= '0;
      digit_q       <= '0;
      an_q          <= ~NUM_DIGITS'(1);
      sseg_q        <= SSEG_BLANK;
    end else begin
      mem_q         <= mem_d;
      offset_q      <= offset_d;
      bounce_dir_q  <= bounce_dir_d;
      scroll_cnt_q  <= scroll_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_q       <= digit_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_banner_scroller.sv
module tb_banner_scroller;

  localparam int ND = 4;
  localparam int ML = 6;
  localparam int SD = 4;
  localparam int RD = 2;
  localparam int AW = 3;
  localparam int MAXOFF = ML - ND;

  // active-high a..g patterns for decimal digits
  localparam logic [6:0] LIT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic reset, enable, dir, mode;
  logic [ND-1:0] an;
  logic [7:0] sseg;

  banner_scroller_if #(.MSG_LEN(ML)) wr_if ();

  banner_scroller #(
    .NUM_DIGITS(ND), .MSG_LEN(ML), .SCROLL_DIV(SD), .REFRESH_DIV(RD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode),
    .wr(wr_if), .an(an), .sseg(sseg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] an;
    logic [7:0]    sseg;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   started = 1'b0;

  // reference model state
  int m_mem [ML];
  int m_off, m_bd, m_scnt, m_rcnt, m_dig;

  function automatic logic [7:0] seg_of(input int g);
    logic [6:0] lit;
    if (g <= 9) begin
      lit = LIT[g];
      return {1'b1, ~lit};
    end
    if (g == 11) return 8'hBF;
    return 8'hFF;
  endfunction

  function automatic void model_step(input logic d, input logic m);
    if (!m) begin
      if (d) m_off = (m_off + ML - 1) % ML;
      else   m_off = (m_off + 1) % ML;
    end else if (MAXOFF == 0) begin
      m_off = 0;
    end else if (m_off > MAXOFF) begin
      m_off = MAXOFF;
      m_bd  = 1;
    end else begin
      if (m_bd == 0 && m_off == MAXOFF) m_bd = 1;
      if (m_bd == 1 && m_off == 0)      m_bd = 0;
      m_off = (m_bd == 1) ? m_off - 1 : m_off + 1;
      if (m_off == MAXOFF) m_bd = 1;
      if (m_off == 0)      m_bd = 0;
    end
  endfunction

  task automatic tick(input logic r, input logic en, input logic d,
                      input logic m, input logic we,
                      input logic [AW-1:0] wa, input logic [3:0] wd);
    exp_t e;
    @(negedge clk);
    reset = r; enable = en; dir = d; mode = m;
    wr_if.wr_en = we; wr_if.wr_addr = wa; wr_if.wr_data = wd;
    if (r) begin
      e.an   = 4'b1110;
      e.sseg = 8'hFF;
    end else begin
      e.an   = ~(ND'(1) << m_dig);
      e.sseg = seg_of(m_mem[(m_off + m_dig) % ML]);
    end
    exp_q.push_back(e);
    started = 1'b1;
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = 10;
      m_off = 0; m_bd = 0; m_scnt = 0; m_rcnt = 0; m_dig = 0;
    end else begin
      if (we && int'(wa) < ML) m_mem[wa] = int'(wd);
      if (en) begin
        if (m_scnt == SD - 1) begin
          m_scnt = 0;
          model_step(d, m);
        end else begin
          m_scnt++;
        end
      end
      if (m_rcnt == RD - 1) begin
        m_rcnt = 0;
        m_dig  = (m_dig + 1) % ND;
      end else begin
        m_rcnt++;
      end
    end
  endtask

  task automatic run(input int n, input logic en, input logic d, input logic m);
    for (int i = 0; i < n; i++) tick(1'b0, en, d, m, 1'b0, '0, '0);
  endtask

  task automatic write_msg(input int base);
    for (int i = 0; i < ML; i++)
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(i), 4'(base + i));
  endtask

  // scroll in the given mode until the model reaches the target offset
  task automatic run_until_off(input int target, input logic d, input logic m);
    int n = 0;
    while (m_off != target && n < 200) begin
      tick(1'b0, 1'b1, d, m, 1'b0, '0, '0);
      n++;
    end
    total++;
    if (m_off != target) begin
      bad++;
      $display("FAIL reach_offset got=%0d want=%0d", m_off, target);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (started) begin
      cyc++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation cyc=%0d an=%b sseg=%h", cyc, an, sseg);
      end else begin
        e = exp_q.pop_front();
        if (an !== e.an || sseg !== e.sseg) begin
          bad++;
          $display("FAIL display cyc=%0d got an=%b sseg=%h want an=%b sseg=%h",
                   cyc, an, sseg, e.an, e.sseg);
        end
      end
    end
  end

  initial begin
    logic cur_mode, cur_dir;
    reset = 1'b1; enable = 1'b0; dir = 1'b0; mode = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;

    // reset and blank refresh
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    run(16, 1'b0, 1'b0, 1'b0);

    // wrap forward over message 1..6
    write_msg(1);
    run(40, 1'b1, 1'b0, 1'b0);

    // wrap backward, then freeze
    run(16, 1'b1, 1'b1, 1'b0);
    run(20, 1'b0, 1'b1, 1'b0);
    run(8, 1'b1, 1'b1, 1'b0);

    // bounce from offset 0
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    write_msg(1);
    run(32, 1'b1, 1'b0, 1'b1);

    // bounce entered with offset beyond the maximum
    run_until_off(4, 1'b0, 1'b0);
    run(12, 1'b1, 1'b0, 1'b1);

    // out-of-range write, then overwrite the glyph on digit 0
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(m_off % ML), 4'hB);
    run(12, 1'b0, 1'b0, 1'b0);

    // reset mid-scroll
    run_until_off(3, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    run(16, 1'b0, 1'b0, 1'b0);

    // randomized traffic
    write_msg(int'($urandom_range(0, 6)));
    cur_mode = 1'b0;
    cur_dir  = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
      if ($urandom_range(0, 15) == 0) cur_dir  = ~cur_dir;
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           cur_dir, cur_mode,
           ($urandom_range(0, 3) == 0),
           AW'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)));
    end

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banner_scroller.md
Name: banner_scroller

Overview:
- Parametrised next-generation scrolling banner for an N-digit multiplexed seven-segment display.
- Holds a writable message of MSG_LEN 4-bit glyph codes and scrolls a NUM_DIGITS-wide window across it at a prescaled rate.
- Scroll modes: wrap (circular, either direction) or bounce (ping-pong between message ends).
- Integrates glyph decoding and time-multiplexed digit refresh; drives anode and segment pins directly.

Parameters:
- NUM_DIGITS, 4, number of physical display digits (>=1).
- MSG_LEN, 10, message length in glyphs (>= NUM_DIGITS).
- SCROLL_DIV, 50_000_000, clk cycles per scroll step while enabled (>=1).
- REFRESH_DIV, 100_000, clk cycles each digit stays lit (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scrolling advances; 0 = scroll frozen, display keeps refreshing.
- dir  in  1  wrap mode only: 0 = offset increments, 1 = offset decrements.
- mode  in  1  0 = wrap, 1 = bounce.
- wr_en  in  1  message write strobe.
- wr_addr  in  clog2(MSG_LEN)  message index to write.
- wr_data  in  4  glyph code.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low.
- sseg  out  8  segments {dp,g..a}, active-low.

Behaviour:
- Single clk domain. reset is synchronous, active-high, and overrides all other inputs.
- Glyph codes:
  - 0x0-0x9 = decimal digits.
  - 0xA = blank.
  - 0xB = '-'.
  - 0xC-0xF = blank.
  - dp is always off (sseg[7]=1).
- Reset state:
  - Message memory all 0xA.
  - offset=0, bounce_dir=0, scroll prescaler=0, refresh counter=0, digit index=0.
  - an = all ones except bit0 = 0.
  - sseg = 8'hFF.
- Write port:
  - When wr_en=1 and wr_addr<MSG_LEN, mem[wr_addr] <= wr_data at the clock edge.
  - wr_addr>=MSG_LEN is ignored.
  - The written glyph is visible on sseg the next time that position is refreshed.
- Scroll prescaler:
  - Counts 0..SCROLL_DIV-1 only while enable=1 and holds while enable=0.
  - A step pulse fires on the cycle the count wraps from SCROLL_DIV-1 to 0.
- Window mapping: digit k (k=0 rightmost, anode bit k) shows mem[(offset+k) mod MSG_LEN]. Compute the index by conditional subtraction, not a divider.
- Wrap mode, on each step:
  - dir=0: offset <= (offset==MSG_LEN-1) ? 0 : offset+1.
  - dir=1: offset <= (offset==0) ? MSG_LEN-1 : offset-1.
- Bounce mode (dir ignored), with MAXOFF = MSG_LEN-NUM_DIGITS:
  - bounce_dir=0: increment; on reaching MAXOFF set bounce_dir=1.
  - bounce_dir=1: decrement; on reaching 0 set bounce_dir=0.
  - The direction flip happens in the same cycle the endpoint is entered, so the endpoint is displayed for exactly one step period.
  - If offset>MAXOFF on a step (mode switched mid-scroll): offset <= MAXOFF, bounce_dir <= 1.
  - MSG_LEN==NUM_DIGITS: offset stays 0.
- Refresh:
  - Counter counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances k -> (k+1) mod NUM_DIGITS, independent of enable.
  - an and sseg are registered together and update in the same cycle, one clk after the digit index changes, so there is no ghosting between them.
- Simultaneous events:
  - A write and a step in the same cycle are both applied.
  - A step and a refresh advance in the same cycle: the newly lit digit uses the pre-step offset for that cycle's registered output.
- Reset mid-scroll returns all state to the reset values above on the next edge.

Decomposition:
- Package banner_pkg holds:
  - glyph code constants (GLYPH_BLANK=4'hA, GLYPH_DASH=4'hB);
  - mode constants (MODE_WRAP=0, MODE_BOUNCE=1);
  - the 7-segment pattern constants for 0-9, blank and dash.
- One combinational sub-module, banner_glyph_decoder: 4-bit glyph code -> 8-bit active-low sseg.
- Prescalers, offset FSM, memory and refresh mux stay in banner_scroller.

Test Plan:
All scenarios use NUM_DIGITS=4, MSG_LEN=6, SCROLL_DIV=4, REFRESH_DIV=2.
1. Reset, then observe for 8 refresh periods -> an cycles 1110,1101,1011,0111, 2 clk each; sseg=8'hFF (blank) on every digit.
2. Write mem = 1,2,3,4,5,6, enable=1, dir=0, mode=0 -> offset steps every 4 clk as 0,1,2,3,4,5,0. At offset=5 the digits k0..k3 show 6,1,2,3.
3. Same message, dir=1 from offset 0 -> next offset 5, then 4. Toggling enable low for 20 clk freezes the offset while an keeps cycling.
4. mode=1 from offset 0 -> offset sequence 0,1,2,1,0,1. Switch to bounce with offset=4 -> next step offset=2, then 1.
5. Write wr_addr=7 -> memory unchanged. Write to the index currently shown on digit 0 -> the new glyph appears at the next digit-0 refresh.
6. Assert reset mid-scroll at offset 3 -> next cycle offset=0, an=1110, sseg=8'hFF, memory all blank.
